meas_mem_loader: RTL

- Upstream of the measurement-unit array; the only writer of its shared memory-write bus.
- Accepts a host word stream (valid/ready) of bursts: one header word followed by N data words.
- Expands each burst into back-to-back writes using the unit-select / cmd-wave / buffer-address scheme, auto-incrementing the address.
- Flags malformed headers without writing to any unit.

---
 rtl/meas_mem_loader.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/meas_mem_loader.sv
// meas_mem_loader: expands host header+data bursts into memory-write strobes
// for the measurement-unit array (sole writer of the shared write bus).
//
// Ports:
//   clk, reset (async, active-low)
//   s_data/s_valid/s_ready : host word stream (header word, then LEN+1 data)
//   abort                  : drops the current burst, blocks s_ready
//   err_clr                : clears the sticky err flag
//   mem_write_addr/data/en : registered write bus, one word per cycle
//   busy, done, err        : status (done pulses with the final write)
//   checksum               : only when MEAS_MEM_LOADER_CHECKSUM_EN is defined
//
// Optional feature macro: MEAS_MEM_LOADER_CHECKSUM_EN
module meas_mem_loader #(
    parameter int DATA_WIDTH  = 32,
    parameter int N_MEAS_UNIT = 8,
    parameter int LOG_N_MEAS  = $clog2(N_MEAS_UNIT),
    parameter int AW          = 13 + LOG_N_MEAS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  abort,
    input  logic                  err_clr,
    output logic [AW-1:0]         mem_write_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write_en,
    output logic                  busy,
    output logic                  done,
`ifdef MEAS_MEM_LOADER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [11:0]           cnt_q, cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [AW-1:0]         wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  err_set;

    logic                  accept;
    logic [LOG_N_MEAS-1:0] unit_sel;
    logic                  unit_bad;
    logic                  rsvd_bad;
    logic                  malformed;
    logic [AW-1:0]         addr_inc;

    // s_ready is forced low both in reset and while abort is pulsed,
    // so an aborting cycle can never also transfer a word.
    assign s_ready = reset & ~abort;
    assign accept  = s_valid & s_ready;

    assign unit_sel = s_data[AW-1:13];

    // A power-of-two unit count cannot produce an out-of-range select.
    generate
        if (N_MEAS_UNIT == (1 << LOG_N_MEAS)) begin : g_unit_full
            assign unit_bad = 1'b0;
        end else begin : g_unit_partial
            localparam logic [LOG_N_MEAS:0] NU =
                (LOG_N_MEAS + 1)'(N_MEAS_UNIT);
            assign unit_bad = {1'b0, unit_sel} >= NU;
        end
    endgenerate

    assign rsvd_bad  = ~s_data[12] & (s_data[11:10] != 2'b00);
    assign malformed = unit_bad | rsvd_bad;

    // cmd path only walks the low byte; wave path walks the full buffer.
    always_comb begin
        addr_inc = addr_q;
        if (addr_q[12]) begin
            addr_inc = {addr_q[AW-1:12], addr_q[11:0] + 12'd1};
        end else begin
            addr_inc = {addr_q[AW-1:8], addr_q[7:0] + 8'd1};
        end
    end

`ifdef MEAS_MEM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        err_set   = 1'b0;
`ifdef MEAS_MEM_LOADER_CHECKSUM_EN
        acc_d     = acc_q;
        csum_d    = csum_q;
`endif
        if (abort) begin
            state_d = IDLE;
            cnt_d   = 12'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_d = s_data[AW-1:0];
                        cnt_d  = s_data[31:20];
`ifdef MEAS_MEM_LOADER_CHECKSUM_EN
                        acc_d  = '0;
`endif
                        if (malformed) begin
                            err_set = 1'b1;
                            state_d = DRAIN;
                        end else begin
                            state_d = LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = s_data;
                        addr_d    = addr_inc;
                        cnt_d     = cnt_q - 12'd1;
`ifdef MEAS_MEM_LOADER_CHECKSUM_EN
                        acc_d     = acc_q + s_data;
`endif
                        if (cnt_q == 12'd0) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
`ifdef MEAS_MEM_LOADER_CHECKSUM_EN
                            csum_d  = acc_q + s_data;
`endif
                        end
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        cnt_d = cnt_q - 12'd1;
                        if (cnt_q == 12'd0) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Set has priority over clear on the same edge.
    assign err_d = err_set | (err_q & ~err_clr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

`ifdef MEAS_MEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            csum_q <= '0;
        end else begin
            acc_q  <= acc_d;
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`endif

    assign mem_write_en   = wr_en_q;
    assign mem_write_addr = wr_addr_q;
    assign mem_write_data = wr_data_q;
    assign done           = done_q;
    assign err            = err_q;
    assign busy           = (state_q == LOAD) || (state_q == DRAIN);

endmodule
